// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the round-robin shared-register arbiter.
// Optional feature macro: SHARED_REG_PARITY_EN (adds q_par to the bus).
package shared_reg_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned IDX_W_DEF   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Bus between producers (master) and the shared-register arbiter (slave).
// Optional feature macro: SHARED_REG_PARITY_EN (adds q_par).
interface shared_reg_arbiter_if
  import shared_reg_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned IDX_W   = IDX_W_DEF
) ();

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic                      clr;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         q;
  logic                      q_valid;
  logic [IDX_W-1:0]          owner;
  logic                      busy;
`ifdef SHARED_REG_PARITY_EN
  logic                      q_par;
`endif

  modport master (
    output req, wdata, clr,
    input  gnt, ack, q, q_valid, owner, busy
`ifdef SHARED_REG_PARITY_EN
    , input q_par
`endif
  );

  modport slave (
    input  req, wdata, clr,
    output gnt, ack, q, q_valid, owner, busy
`ifdef SHARED_REG_PARITY_EN
    , output q_par
`endif
  );

endinterface

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request after i_last, wrapping.
module rr_pick
  import shared_reg_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned IDX_W   = IDX_W_DEF
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [IDX_W-1:0]   o_sel,
  output logic               o_any
);

  // Scan from last+1 upward; the first hit wins.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    o_sel = '0;
    o_any = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(i_last) + k) % NUM_REQ;
      if (!o_any && i_req[IDX_W'(idx)]) begin
        o_any = 1'b1;
        o_sel = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sequencing grant/write/ack into one shared register.
// Optional feature macro: SHARED_REG_PARITY_EN (registered even parity of q on q_par).
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned IDX_W   = IDX_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  shared_reg_arbiter_if.slave bus
);

  state_t               r_state;
  logic [IDX_W-1:0]     r_sel;
  logic [IDX_W-1:0]     r_last;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [NUM_REQ-1:0]   r_ack;
  logic [DATA_W-1:0]    r_q;
  logic                 r_q_valid;
  logic [IDX_W-1:0]     r_owner;
  logic                 r_busy;
`ifdef SHARED_REG_PARITY_EN
  logic                 r_q_par;
`endif

  logic [IDX_W-1:0]     w_sel;
  logic                 w_any;
  logic [NUM_REQ-1:0]   w_sel_oh;
  logic [NUM_REQ-1:0]   w_cur_oh;
  logic                 w_req_cur;
  logic [DATA_W-1:0]    w_lane;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req  (bus.req),
    .i_last (r_last),
    .o_sel  (w_sel),
    .o_any  (w_any)
  );

  // Decode of the candidate and the held selection.
  always_comb begin
    w_sel_oh  = NUM_REQ'(1) << w_sel;
    w_cur_oh  = NUM_REQ'(1) << r_sel;
    w_req_cur = bus.req[r_sel];
    w_lane    = bus.wdata[32'(r_sel)*DATA_W +: DATA_W];
  end

  // Arbitration FSM plus shared storage; a write in GRANT overrides a same-cycle clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_sel     <= '0;
      r_last    <= IDX_W'(NUM_REQ - 1);
      r_gnt     <= '0;
      r_ack     <= '0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_owner   <= '0;
      r_busy    <= 1'b0;
`ifdef SHARED_REG_PARITY_EN
      r_q_par   <= 1'b0;
`endif
    end else begin
      if (bus.clr) begin
        r_q       <= '0;
        r_q_valid <= 1'b0;
`ifdef SHARED_REG_PARITY_EN
        r_q_par   <= 1'b0;
`endif
      end
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_sel   <= w_sel;
            r_gnt   <= w_sel_oh;
            r_busy  <= 1'b1;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          r_gnt <= '0;
          if (w_req_cur) begin
            r_q       <= w_lane;
            r_q_valid <= 1'b1;
`ifdef SHARED_REG_PARITY_EN
            r_q_par   <= ^w_lane;
`endif
            r_owner   <= r_sel;
            r_last    <= r_sel;
            r_ack     <= w_cur_oh;
            r_state   <= ST_ACK;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_ACK: begin
          r_ack   <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_gnt   <= '0;
          r_ack   <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.ack     = r_ack;
  assign bus.q       = r_q;
  assign bus.q_valid = r_q_valid;
  assign bus.owner   = r_owner;
  assign bus.busy    = r_busy;
`ifdef SHARED_REG_PARITY_EN
  assign bus.q_par   = r_q_par;
`endif

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter with a behavioural round-robin model.
module tb_shared_reg_arbiter;
  import shared_reg_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int NW = N * W;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  // Reference model state
  int         m_last;
  logic [7:0] m_q;
  logic       m_valid;
  int         m_owner;

  shared_reg_arbiter_if #(.NUM_REQ(N), .DATA_W(W), .IDX_W(2)) bus ();

  shared_reg_arbiter #(.NUM_REQ(N), .DATA_W(W), .IDX_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout exp finish");
    $fatal(1);
  end

  function automatic int pick(input logic [N-1:0] r, input int last);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (last + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req   = '0;
    bus.wdata = '0;
    bus.clr   = 1'b0;
    rst       = 1'b1;
    tick();
    tick();
    #2;
    rst       = 1'b0;
    m_last    = N - 1;
    m_q       = '0;
    m_valid   = 1'b0;
    m_owner   = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy); else n_pass++;
    // complete a write so q is nonzero, then reset mid-grant without an edge
    bus.req = 4'b0001; bus.wdata = 32'h0000_003C;
    tick(); tick(); bus.req = '0; tick();
    n_total++; if (bus.q !== 8'h3C) $display("FAIL reset_prewrite got %h exp 3c", bus.q); else n_pass++;
    bus.req = 4'b0001;
    tick();
    #2; rst = 1'b1; #1;
    n_total++; if (bus.q !== 8'h00) $display("FAIL reset_q got %h exp 00", bus.q); else n_pass++;
    n_total++; if (bus.q_valid !== 1'b0) $display("FAIL reset_qv got %b exp 0", bus.q_valid); else n_pass++;
    n_total++; if (bus.gnt !== 4'b0) $display("FAIL reset_gnt got %b exp 0000", bus.gnt); else n_pass++;
    n_total++; if (bus.ack !== 4'b0) $display("FAIL reset_ack got %b exp 0000", bus.ack); else n_pass++;
    n_total++; if (bus.owner !== 2'd0) $display("FAIL reset_owner got %0d exp 0", bus.owner); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy2 got %b exp 0", bus.busy); else n_pass++;
    do_reset();
  endtask

  task automatic test_single();
    bus.req = 4'b0100; bus.wdata = 32'h00A5_0000;
    tick();
    n_total++; if (bus.gnt !== 4'b0100) $display("FAIL single_gnt got %b exp 0100", bus.gnt); else n_pass++;
    n_total++; if (bus.busy !== 1'b1) $display("FAIL single_busy got %b exp 1", bus.busy); else n_pass++;
    tick();
    n_total++; if (bus.q !== 8'hA5) $display("FAIL single_q got %h exp a5", bus.q); else n_pass++;
    n_total++; if (bus.ack !== 4'b0100) $display("FAIL single_ack got %b exp 0100", bus.ack); else n_pass++;
    n_total++; if (bus.gnt !== 4'b0000) $display("FAIL single_gnt_off got %b exp 0000", bus.gnt); else n_pass++;
    n_total++; if (bus.owner !== 2'd2) $display("FAIL single_owner got %0d exp 2", bus.owner); else n_pass++;
    n_total++; if (bus.q_valid !== 1'b1) $display("FAIL single_qv got %b exp 1", bus.q_valid); else n_pass++;
    bus.req = '0;
    tick();
    n_total++; if (bus.busy !== 1'b0) $display("FAIL single_idle got %b exp 0", bus.busy); else n_pass++;
    n_total++; if (bus.ack !== 4'b0) $display("FAIL single_ack_off got %b exp 0000", bus.ack); else n_pass++;
  endtask

  task automatic test_contention();
    logic [7:0] lanes [4];
    int         exp_order [5];
    lanes = '{8'h10, 8'h21, 8'h32, 8'h43};
    exp_order = '{0, 1, 2, 3, 0};
    do_reset();
    bus.req = 4'b1111; bus.wdata = 32'h4332_2110;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_total++; if (bus.gnt !== 4'(1 << exp_order[k])) $display("FAIL cont_gnt%0d got %b exp %b", k, bus.gnt, 4'(1 << exp_order[k])); else n_pass++;
      tick();
      n_total++; if (bus.ack !== 4'(1 << exp_order[k])) $display("FAIL cont_ack%0d got %b exp %b", k, bus.ack, 4'(1 << exp_order[k])); else n_pass++;
      n_total++; if (bus.q !== lanes[exp_order[k]]) $display("FAIL cont_q%0d got %h exp %h", k, bus.q, lanes[exp_order[k]]); else n_pass++;
      tick();
      n_total++; if (bus.busy !== 1'b0) $display("FAIL cont_idle%0d got %b exp 0", k, bus.busy); else n_pass++;
    end
    bus.req = '0;
    tick();
    m_last = 0; m_q = 8'h10; m_valid = 1'b1; m_owner = 0;
  endtask

  task automatic test_abort();
    bus.req = 4'b0010; bus.wdata = 32'h0000_EE00;
    tick();
    n_total++; if (bus.gnt !== 4'b0010) $display("FAIL abort_gnt got %b exp 0010", bus.gnt); else n_pass++;
    bus.req = '0;
    tick();
    n_total++; if (bus.ack !== 4'b0) $display("FAIL abort_ack got %b exp 0000", bus.ack); else n_pass++;
    n_total++; if (bus.q !== 8'h10) $display("FAIL abort_q got %h exp 10", bus.q); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", bus.busy); else n_pass++;
    // pointer must still be 0, so requester 1 wins over 0
    bus.req = 4'b0011; bus.wdata = 32'h0000_7711;
    tick();
    n_total++; if (bus.gnt !== 4'b0010) $display("FAIL abort_ptr got %b exp 0010", bus.gnt); else n_pass++;
    bus.req = 4'b0010;
    tick();
    n_total++; if (bus.owner !== 2'd1) $display("FAIL abort_owner got %0d exp 1", bus.owner); else n_pass++;
    bus.req = '0;
    tick();
    m_last = 1; m_q = 8'h77; m_owner = 1;
  endtask

  task automatic test_clr();
    bus.req = 4'b0010; bus.wdata = 32'h0000_5A00;
    tick();
    bus.clr = 1'b1;
    tick();
    n_total++; if (bus.q !== 8'h5A) $display("FAIL clr_collide_q got %h exp 5a", bus.q); else n_pass++;
    n_total++; if (bus.q_valid !== 1'b1) $display("FAIL clr_collide_qv got %b exp 1", bus.q_valid); else n_pass++;
`ifdef SHARED_REG_PARITY_EN
    n_total++; if (bus.q_par !== 1'b0) $display("FAIL clr_collide_par got %b exp 0", bus.q_par); else n_pass++;
`endif
    bus.clr = 1'b0; bus.req = '0;
    tick();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    n_total++; if (bus.q !== 8'h00) $display("FAIL clr_idle_q got %h exp 00", bus.q); else n_pass++;
    n_total++; if (bus.q_valid !== 1'b0) $display("FAIL clr_idle_qv got %b exp 0", bus.q_valid); else n_pass++;
    n_total++; if (bus.owner !== 2'd1) $display("FAIL clr_owner got %0d exp 1", bus.owner); else n_pass++;
    m_last = 1; m_q = '0; m_valid = 1'b0; m_owner = 1;
  endtask

  task automatic test_reset_midop();
    bus.req = 4'b0100; bus.wdata = 32'h0099_0000;
    tick();
    #2; rst = 1'b1; #1;
    n_total++; if (bus.gnt !== 4'b0) $display("FAIL rstmid_gnt got %b exp 0000", bus.gnt); else n_pass++;
    tick();
    n_total++; if (bus.ack !== 4'b0) $display("FAIL rstmid_ack got %b exp 0000", bus.ack); else n_pass++;
    n_total++; if (bus.q !== 8'h00) $display("FAIL rstmid_q got %h exp 00", bus.q); else n_pass++;
    bus.req = '0;
    #2; rst = 1'b0;
    m_last = N - 1; m_q = '0; m_valid = 1'b0; m_owner = 0;
    bus.req = 4'b1001; bus.wdata = 32'h0000_0007;
    tick();
    n_total++; if (bus.gnt !== 4'b0001) $display("FAIL rstmid_first got %b exp 0001", bus.gnt); else n_pass++;
    bus.req = 4'b0001;
    tick();
    n_total++; if (bus.q !== 8'h07) $display("FAIL rstmid_wq got %h exp 07", bus.q); else n_pass++;
`ifdef SHARED_REG_PARITY_EN
    n_total++; if (bus.q_par !== 1'b1) $display("FAIL rstmid_par got %b exp 1", bus.q_par); else n_pass++;
`endif
    bus.req = '0;
    tick();
    m_last = 0; m_q = 8'h07; m_valid = 1'b1; m_owner = 0;
  endtask

  task automatic test_random();
    logic [N-1:0]  r;
    logic [NW-1:0] wd;
    logic          c;
    logic          ab;
    int            sel;
    logic [7:0]    lane;
    for (int it = 0; it < 60; it++) begin
      r  = 4'($urandom_range(0, 15));
      wd = 32'($urandom());
      bus.req = r; bus.wdata = wd; bus.clr = 1'b0;
      if (r == 0) begin
        c = ($urandom_range(0, 3) == 0);
        bus.clr = c;
        tick();
        if (c) begin m_q = '0; m_valid = 1'b0; end
        n_total++; if (bus.busy !== 1'b0) $display("FAIL rnd_idle%0d got %b exp 0", it, bus.busy); else n_pass++;
        n_total++; if (bus.q !== m_q || bus.q_valid !== m_valid) $display("FAIL rnd_hold%0d got %h/%b exp %h/%b", it, bus.q, bus.q_valid, m_q, m_valid); else n_pass++;
      end else begin
        sel = pick(r, m_last);
        tick();
        n_total++; if (bus.gnt !== 4'(1 << sel)) $display("FAIL rnd_gnt%0d got %b exp %b", it, bus.gnt, 4'(1 << sel)); else n_pass++;
        ab = ($urandom_range(0, 4) == 0);
        c  = ($urandom_range(0, 2) == 0);
        bus.clr = c;
        if (ab) bus.req[sel] = 1'b0;
        tick();
        if (ab) begin
          if (c) begin m_q = '0; m_valid = 1'b0; end
          n_total++; if (bus.ack !== 4'b0 || bus.busy !== 1'b0) $display("FAIL rnd_abort%0d got %b/%b exp 0000/0", it, bus.ack, bus.busy); else n_pass++;
        end else begin
          lane = wd[sel*W +: W];
          m_q = lane; m_valid = 1'b1; m_owner = sel; m_last = sel;
          n_total++; if (bus.ack !== 4'(1 << sel)) $display("FAIL rnd_ack%0d got %b exp %b", it, bus.ack, 4'(1 << sel)); else n_pass++;
          n_total++; if (bus.owner !== 2'(m_owner)) $display("FAIL rnd_owner%0d got %0d exp %0d", it, bus.owner, m_owner); else n_pass++;
        end
        n_total++; if (bus.q !== m_q || bus.q_valid !== m_valid) $display("FAIL rnd_q%0d got %h/%b exp %h/%b", it, bus.q, bus.q_valid, m_q, m_valid); else n_pass++;
`ifdef SHARED_REG_PARITY_EN
        n_total++; if (bus.q_par !== ^m_q) $display("FAIL rnd_par%0d got %b exp %b", it, bus.q_par, ^m_q); else n_pass++;
`endif
        bus.req = '0; bus.clr = 1'b0;
        if (!ab) begin
          tick();
          n_total++; if (bus.ack !== 4'b0 || bus.busy !== 1'b0) $display("FAIL rnd_done%0d got %b/%b exp 0000/0", it, bus.ack, bus.busy); else n_pass++;
        end
      end
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_abort();
    test_clr();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin arbiter granting NUM_REQ requesters exclusive write access to one shared DATA_W-bit D-flip-flop register.
- Sequences each access as grant, write, then acknowledge.
- Exposes the register contents, a valid flag and the index of the last writer to downstream logic.
- Sits between multiple producer blocks and a single storage flop bank.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DATA_W, 8, width of the shared register and of each write-data lane
- IDX_W, 2, width of owner index, must equal clog2(NUM_REQ)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- req  input  NUM_REQ  per-requester write request, level, held until ack
- wdata  input  NUM_REQ*DATA_W  flattened write data; lane i is bits [i*DATA_W +: DATA_W]
- clr  input  1  synchronous clear of q and q_valid
- gnt  output  NUM_REQ  one-hot grant, registered
- ack  output  NUM_REQ  one-hot one-cycle completion pulse, registered
- q  output  DATA_W  shared register contents
- q_valid  output  1  q holds data written since reset/clr
- owner  output  IDX_W  index of last requester that completed a write
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, gnt=0, ack=0, q=0, q_valid=0, owner=0, busy=0, rr pointer last=NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, GRANT, ACK.
- IDLE:
  - If req!=0, select the first asserted req searching from last+1 upward, wrapping modulo NUM_REQ.
  - Next edge: gnt=onehot(sel), state=GRANT.
  - Else remain IDLE.
- GRANT:
  - If req[sel] still 1: next edge q<=wdata lane sel, q_valid<=1, owner<=sel, last<=sel, ack[sel]<=1, gnt<=0, state=ACK.
  - If req[sel] dropped: abort. gnt<=0, no write, no ack, last unchanged, state=IDLE.
- ACK:
  - ack cleared next edge; state=IDLE.
  - req[sel] sampled during ACK is ignored; the requester must drop req on seeing ack.
- Latency: req seen at edge N → gnt high after edge N+1 → q updated and ack high after edge N+2 → IDLE after edge N+3. Back-to-back accesses every 3 cycles.
- busy=1 in GRANT and ACK.
- wdata of the granted lane must be stable in GRANT. Other lanes are don't-care.
- Requests arriving while busy wait. No request is lost while its req stays asserted.
- clr (any state): next edge q<=0, q_valid<=0. FSM, pointer and owner are unaffected.
- clr in the same cycle as a GRANT-state write: write wins, q=wdata, q_valid=1.
- Only the selected lane is written. q holds its value in all other cycles (pure flop storage, no latch).
- gnt and ack are never simultaneously nonzero and are always one-hot or zero.
- rst asserted mid-operation: immediate return to reset values; any pending write is discarded.
- Fairness: with all req held, grant order is 0,1,...,NUM_REQ-1,0,...

Optional Feature:
- SHARED_REG_PARITY_EN
- Defined:
  - Adds output q_par (1 bit), a registered even parity of q, updated on the same edge as q.
  - Reset value 0, cleared by clr.
- Undefined: port absent, no parity logic.

Decomposition:
- Package shared_reg_pkg:
  - state enum/localparams ST_IDLE=2'd0, ST_GRANT=2'd1, ST_ACK=2'd2
  - default NUM_REQ/DATA_W constants
- Sub-module rr_pick:
  - combinational round-robin selector
  - inputs: req vector, last index
  - outputs: sel index, any flag
  - reusable by other arbiters in the design
- FSM and storage remain in the top.

Test Plan:
- Reset: assert rst mid-cycle → q=0, q_valid=0, gnt=0, ack=0, owner=0, busy=0 immediately without a clock edge.
- Single request: req=4'b0100, lane2=8'hA5 → gnt=0100 after 1 edge; after 2 edges q=8'hA5, ack=0100, owner=2, q_valid=1; after 3 edges busy=0.
- Contention: req=4'b1111 held, lanes=8'h10,8'h21,8'h32,8'h43 (lane0..lane3) → acks in order 0,1,2,3,0; q sequence 10,21,32,43,10; 3 cycles per access.
- Abort: req=4'b0010, drop req during GRANT → no ack, q unchanged; a following req=4'b0010 is still granted (pointer not advanced).
- clr collision: clr=1 in the GRANT-state write cycle with lane1=8'h5A → q=8'h5A, q_valid=1. clr=1 alone in IDLE → q=0, q_valid=0.
- Reset mid-op: rst during GRANT → gnt=0, no ack, q=0, pointer reset, so req=4'b1001 then grants 0 first; with SHARED_REG_PARITY_EN, q=8'h07 → q_par=1.
